// File: rtl/can_defs.sv
// Shared types for the CAN receive message path: stored message layout,
// controller FSM states and the acceptance-filter decision.
package can_defs;

    typedef struct packed {
        logic [10:0]     id_std;
        logic [17:0]     id_ext;
        logic            ide;
        logic            rtr;
        logic [3:0]      dlc;
        logic [0:7][7:0] data;
    } rx_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_STORE  = 2'd2
    } rx_state_e;

    // Mask bit 1 means the id bit must equal the code bit; the extended
    // part only takes part in the decision for extended frames.
    function automatic logic frame_accept(input rx_msg_t msg, input logic en,
                                          input logic [28:0] code,
                                          input logic [28:0] mask);
        logic std_ok;
        logic ext_ok;
        std_ok = ((msg.id_std ^ code[28:18]) & mask[28:18]) == 11'd0;
        ext_ok = ((msg.id_ext ^ code[17:0]) & mask[17:0]) == 18'd0;
        return !en || (std_ok && (!msg.ide || ext_ok));
    endfunction

endpackage

// File: rtl/can_msg_fifo.sv
// Message FIFO of DEPTH rx_msg_t entries with push/pop/flush and an
// occupancy count; the head entry reads as zero while empty.
module can_msg_fifo
    import can_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  rx_msg_t                  wr_msg,
    output rx_msg_t                  rd_msg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    rx_msg_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            pop_en;
    logic            push_en;

    // A pop frees the slot the same cycle, so a write into a full FIFO is
    // allowed when it coincides with a pop.
    always_comb begin
        pop_en   = pop && (count_q != '0) && !flush;
        push_en  = push && ((count_q != FULL_CNT) || pop_en) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !rst) mem[wr_ptr_q] <= wr_msg;
    end

    assign rd_msg = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count  = count_q;

endmodule

// File: rtl/can_rx_msg_ctrl.sv
// CAN receive message controller: edge-detects completed frames, snapshots
// them, applies the acceptance filter and queues accepted frames for the host.
module can_rx_msg_ctrl
    import can_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done_flag,
    input  logic [10:0]              rx_id_std,
    input  logic [17:0]              rx_id_ext,
    input  logic                     rx_ide,
    input  logic                     rx_remote_req,
    input  logic [3:0]               rx_dlc,
    input  logic [7:0]               rx_data [0:7],
    input  logic                     filter_en,
    input  logic [28:0]              acc_code,
    input  logic [28:0]              acc_mask,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     clr_overrun,
    output logic                     out_valid,
    output logic [10:0]              out_id_std,
    output logic [17:0]              out_id_ext,
    output logic                     out_ide,
    output logic                     out_rtr,
    output logic [3:0]               out_dlc,
    output logic [7:0]               out_data [0:7],
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rx_state_e       state_q, state_d;
    rx_msg_t         snap_q, snap_d;
    rx_msg_t         rx_msg;
    rx_msg_t         head;
    logic            rx_done_q;
    logic            accept_q, accept_d;
    logic            overrun_q, overrun_d;
    logic            edge_det;
    logic            capture;
    logic            store_en;
    logic            push;
    logic            pop;
    logic            ovr_set;
    logic [CW-1:0]   count;

    always_comb begin
        rx_msg.id_std = rx_id_std;
        rx_msg.id_ext = rx_id_ext;
        rx_msg.ide    = rx_ide;
        rx_msg.rtr    = rx_remote_req;
        rx_msg.dlc    = rx_dlc;
        for (int i = 0; i < 8; i++) rx_msg.data[i] = rx_data[i];
    end

    assign edge_det = rx_done_flag && !rx_done_q;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (edge_det) state_d = ST_FILTER;
                ST_FILTER: state_d = ST_STORE;
                ST_STORE:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        capture  = (state_q == ST_IDLE) && edge_det && !flush;
        store_en = (state_q == ST_STORE) && accept_q && !flush;
    end

    // Overrun covers both a full FIFO at store time and a frame arriving
    // while the previous one is still in flight; setting beats clearing.
    always_comb begin
        snap_d   = capture ? rx_msg : snap_q;
        accept_d = accept_q;
        if (state_q == ST_FILTER)
            accept_d = frame_accept(snap_q, filter_en, acc_code, acc_mask);
        if (flush) begin
            snap_d   = '0;
            accept_d = 1'b0;
        end
        push      = store_en && ((count != FULL_CNT) || pop);
        ovr_set   = (edge_det && busy) || (store_en && (count == FULL_CNT) && !pop);
        overrun_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            snap_q    <= '0;
            accept_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done_flag;
            snap_q    <= snap_d;
            accept_q  <= accept_d;
            overrun_q <= overrun_d;
        end
    end

    can_msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wr_msg (snap_q),
        .rd_msg (head),
        .count  (count)
    );

    assign out_valid  = (count != '0);
    assign out_id_std = head.id_std;
    assign out_id_ext = head.id_ext;
    assign out_ide    = head.ide;
    assign out_rtr    = head.rtr;
    assign out_dlc    = head.dlc;
    assign fifo_count = count;
    assign overrun    = overrun_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_out_data
        assign out_data[gi] = head.data[gi];
    end

endmodule

// File: tb/tb_can_rx_msg_ctrl.sv
// Scenario bench for can_rx_msg_ctrl: expected frames are queued as they are
// sent and compared against the FIFO head whenever the host pops.
module tb_can_rx_msg_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [10:0] s;
        logic [17:0] e;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] d;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx_done_flag;
    logic [10:0]    rx_id_std;
    logic [17:0]    rx_id_ext;
    logic           rx_ide;
    logic           rx_remote_req;
    logic [3:0]     rx_dlc;
    logic [7:0]     rx_data [0:7];
    logic           filter_en;
    logic [28:0]    acc_code;
    logic [28:0]    acc_mask;
    logic           out_ready;
    logic           flush;
    logic           clr_overrun;
    logic           out_valid;
    logic [10:0]    out_id_std;
    logic [17:0]    out_id_ext;
    logic           out_ide;
    logic           out_rtr;
    logic [3:0]     out_dlc;
    logic [7:0]     out_data [0:7];
    logic [CW-1:0]  fifo_count;
    logic           overrun;
    logic           busy;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];
    exp_t mon_x;
    exp_t mon_a;

    always #5 clk = ~clk;

    can_rx_msg_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_done_flag  (rx_done_flag),
        .rx_id_std     (rx_id_std),
        .rx_id_ext     (rx_id_ext),
        .rx_ide        (rx_ide),
        .rx_remote_req (rx_remote_req),
        .rx_dlc        (rx_dlc),
        .rx_data       (rx_data),
        .filter_en     (filter_en),
        .acc_code      (acc_code),
        .acc_mask      (acc_mask),
        .out_ready     (out_ready),
        .flush         (flush),
        .clr_overrun   (clr_overrun),
        .out_valid     (out_valid),
        .out_id_std    (out_id_std),
        .out_id_ext    (out_id_ext),
        .out_ide       (out_ide),
        .out_rtr       (out_rtr),
        .out_dlc       (out_dlc),
        .out_data      (out_data),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .busy          (busy)
    );

    // Scoreboard consumer: each accepted pop must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_a.s   = out_id_std;
            mon_a.e   = out_id_ext;
            mon_a.ide = out_ide;
            mon_a.rtr = out_rtr;
            mon_a.dlc = out_dlc;
            for (int i = 0; i < 8; i++) mon_a.d[63-8*i -: 8] = out_data[i];
            total++;
            if (sb.size() == 0) begin
                $display("FAIL pop_head: got %h, required no entry", mon_a);
            end else begin
                mon_x = sb.pop_front();
                if (mon_a !== mon_x) $display("FAIL pop_head: got %h, required %h", mon_a, mon_x);
                else begin
                    passed++;
                    $display("pop id_std=%h id_ext=%h ide=%b rtr=%b dlc=%h data=%h", mon_a.s, mon_a.e, mon_a.ide, mon_a.rtr, mon_a.dlc, mon_a.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic exp_t mk(input logic [10:0] s, input logic [17:0] e, input logic ide,
                                input logic rtr, input logic [3:0] dlc, input logic [63:0] d);
        exp_t x;
        x.s = s; x.e = e; x.ide = ide; x.rtr = rtr; x.dlc = dlc; x.d = d;
        return x;
    endfunction

    task automatic load_frame(input exp_t f);
        rx_id_std     = f.s;
        rx_id_ext     = f.e;
        rx_ide        = f.ide;
        rx_remote_req = f.rtr;
        rx_dlc        = f.dlc;
        for (int i = 0; i < 8; i++) rx_data[i] = f.d[63-8*i -: 8];
    endtask

    // One-cycle done pulse, then enough cycles for the frame to finish.
    task automatic send_frame(input exp_t f, input bit store);
        load_frame(f);
        rx_done_flag = 1'b1;
        if (store) sb.push_back(f);
        tick();
        rx_done_flag = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_count != '0; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total += 6;
        if (out_valid !== 1'b0)   $display("FAIL reset_valid: got %b, required 0", out_valid); else passed++;
        if (fifo_count !== '0)    $display("FAIL reset_count: got %0d, required 0", fifo_count); else passed++;
        if (overrun !== 1'b0)     $display("FAIL reset_overrun: got %b, required 0", overrun); else passed++;
        if (busy !== 1'b0)        $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
        if (out_id_std !== 11'h0 || out_dlc !== 4'h0) $display("FAIL reset_fields: got id %h dlc %h, required 0", out_id_std, out_dlc); else passed++;
        if (out_data[0] !== 8'h0) $display("FAIL reset_data: got %h, required 0", out_data[0]); else passed++;
        $display("reset done");
    endtask

    task automatic test_basic();
        filter_en = 1'b0;
        load_frame(mk(11'h123, 18'h0, 1'b0, 1'b0, 4'd2, 64'hAA55_0000_0000_0000));
        sb.push_back(mk(11'h123, 18'h0, 1'b0, 1'b0, 4'd2, 64'hAA55_0000_0000_0000));
        rx_done_flag = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy); else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL basic_lat_n2: got %b, required 0", out_valid); else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || fifo_count !== CW'(1)) $display("FAIL basic_lat_n3: got valid %b count %0d, required 1/1", out_valid, fifo_count); else passed++;
        repeat (2) tick();
        rx_done_flag = 1'b0;
        repeat (4) tick();
        total += 3;
        if (fifo_count !== CW'(1)) $display("FAIL basic_one_entry: got %0d, required 1", fifo_count); else passed++;
        if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b, required 0", overrun); else passed++;
        if (out_id_std !== 11'h123 || out_dlc !== 4'd2 || out_data[0] !== 8'hAA || out_data[1] !== 8'h55)
            $display("FAIL basic_fields: got id %h dlc %h d0 %h d1 %h, required 123/2/aa/55", out_id_std, out_dlc, out_data[0], out_data[1]);
        else passed++;
        drain();
        total++;
        if (fifo_count !== '0 || sb.size() != 0) $display("FAIL basic_drain: got count %0d left %0d, required 0/0", fifo_count, sb.size()); else passed++;
    endtask

    task automatic test_filter_std();
        filter_en = 1'b1;
        acc_code  = {11'h123, 18'h0};
        acc_mask  = {11'h7FF, 18'h0};
        send_frame(mk(11'h123, 18'h0, 1'b0, 1'b0, 4'd1, 64'h1111_2222_3333_4444), 1'b1);
        send_frame(mk(11'h124, 18'h0, 1'b0, 1'b0, 4'd1, 64'h5555_6666_7777_8888), 1'b0);
        total += 2;
        if (fifo_count !== CW'(1) || out_id_std !== 11'h123) $display("FAIL filt_std: got count %0d id %h, required 1/123", fifo_count, out_id_std); else passed++;
        if (overrun !== 1'b0) $display("FAIL filt_std_ovr: got %b, required 0", overrun); else passed++;
        drain();
        total++;
        if (fifo_count !== '0 || sb.size() != 0) $display("FAIL filt_std_drain: got count %0d left %0d, required 0/0", fifo_count, sb.size()); else passed++;
    endtask

    task automatic test_filter_ext();
        filter_en = 1'b1;
        acc_code  = {11'h000, 18'h2ABCD};
        acc_mask  = {11'h000, 18'h3FFFF};
        send_frame(mk(11'h7FF, 18'h2ABCD, 1'b1, 1'b0, 4'd8, 64'hDEAD_BEEF_0102_0304), 1'b1);
        send_frame(mk(11'h7FF, 18'h2ABCC, 1'b1, 1'b0, 4'd8, 64'hCAFE_F00D_0506_0708), 1'b0);
        send_frame(mk(11'h042, 18'h00001, 1'b0, 1'b0, 4'd3, 64'h0A0B_0C0D_0E0F_1011), 1'b1);
        total += 3;
        if (fifo_count !== CW'(2)) $display("FAIL filt_ext_count: got %0d, required 2", fifo_count); else passed++;
        if (overrun !== 1'b0) $display("FAIL filt_ext_ovr: got %b, required 0", overrun); else passed++;
        if (out_id_ext !== 18'h2ABCD || out_ide !== 1'b1) $display("FAIL filt_ext_head: got %h ide %b, required 2abcd/1", out_id_ext, out_ide); else passed++;
        drain();
        total++;
        if (fifo_count !== '0 || sb.size() != 0) $display("FAIL filt_ext_drain: got count %0d left %0d, required 0/0", fifo_count, sb.size()); else passed++;
    endtask

    task automatic test_overrun();
        filter_en = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_frame(mk(11'h100 + 11'(i), 18'(i), 1'(i % 2), (i == 2), (i == 3) ? 4'hF : 4'd8,
                          64'h0123_4567_89AB_CDEF ^ {8{8'(i)}}), (i < 4));
        total += 3;
        if (fifo_count !== CW'(4)) $display("FAIL ovr_count: got %0d, required 4", fifo_count); else passed++;
        if (overrun !== 1'b1) $display("FAIL ovr_set: got %b, required 1", overrun); else passed++;
        if (out_id_std !== 11'h100) $display("FAIL ovr_head: got %h, required 100", out_id_std); else passed++;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0 || fifo_count !== CW'(4)) $display("FAIL ovr_clear: got ovr %b count %0d, required 0/4", overrun, fifo_count); else passed++;
    endtask

    task automatic test_full_pop();
        load_frame(mk(11'h555, 18'h15555, 1'b1, 1'b0, 4'd9, 64'hFEDC_BA98_7654_3210));
        sb.push_back(mk(11'h555, 18'h15555, 1'b1, 1'b0, 4'd9, 64'hFEDC_BA98_7654_3210));
        rx_done_flag = 1'b1;
        tick();
        rx_done_flag = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total += 2;
        if (fifo_count !== CW'(4)) $display("FAIL full_pop_count: got %0d, required 4", fifo_count); else passed++;
        if (overrun !== 1'b0) $display("FAIL full_pop_ovr: got %b, required 0", overrun); else passed++;
        drain();
        total++;
        if (fifo_count !== '0 || sb.size() != 0) $display("FAIL full_pop_drain: got count %0d left %0d, required 0/0", fifo_count, sb.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        filter_en = 1'b0;
        load_frame(mk(11'h321, 18'h0, 1'b0, 1'b0, 4'd4, 64'h1234_5678_9ABC_DEF0));
        sb.push_back(mk(11'h321, 18'h0, 1'b0, 1'b0, 4'd4, 64'h1234_5678_9ABC_DEF0));
        rx_done_flag = 1'b1;
        tick();
        rx_done_flag = 1'b0;
        tick();
        load_frame(mk(11'h322, 18'h0, 1'b0, 1'b0, 4'd4, 64'h0));
        rx_done_flag = 1'b1;
        clr_overrun  = 1'b1;
        tick();
        rx_done_flag = 1'b0;
        clr_overrun  = 1'b0;
        total++;
        if (overrun !== 1'b1) $display("FAIL b2b_set_wins: got %b, required 1", overrun); else passed++;
        repeat (3) tick();
        total++;
        if (fifo_count !== CW'(1) || busy !== 1'b0) $display("FAIL b2b_dropped: got count %0d busy %b, required 1/0", fifo_count, busy); else passed++;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) $display("FAIL b2b_clear: got %b, required 0", overrun); else passed++;
        drain();
        total++;
        if (fifo_count !== '0 || sb.size() != 0) $display("FAIL b2b_drain: got count %0d left %0d, required 0/0", fifo_count, sb.size()); else passed++;
    endtask

    task automatic test_flush_rst();
        filter_en = 1'b0;
        send_frame(mk(11'h011, 18'h0, 1'b0, 1'b0, 4'd1, 64'h1), 1'b1);
        send_frame(mk(11'h022, 18'h0, 1'b0, 1'b0, 4'd1, 64'h2), 1'b1);
        total++;
        if (fifo_count !== CW'(2)) $display("FAIL flush_pre: got %0d, required 2", fifo_count); else passed++;
        load_frame(mk(11'h033, 18'h0, 1'b0, 1'b0, 4'd1, 64'h3));
        rx_done_flag = 1'b1;
        tick();
        rx_done_flag = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        total++;
        if (fifo_count !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || out_id_std !== 11'h0)
            $display("FAIL flush_state: got count %0d valid %b busy %b id %h, required 0/0/0/0", fifo_count, out_valid, busy, out_id_std);
        else passed++;
        repeat (3) tick();
        total++;
        if (fifo_count !== '0) $display("FAIL flush_nowrite: got %0d, required 0", fifo_count); else passed++;
        load_frame(mk(11'h044, 18'h0, 1'b0, 1'b0, 4'd1, 64'h4));
        rx_done_flag = 1'b1;
        tick();
        rx_done_flag = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || fifo_count !== '0 || overrun !== 1'b0) $display("FAIL rst_state: got busy %b count %0d ovr %b, required 0/0/0", busy, fifo_count, overrun); else passed++;
        repeat (3) tick();
        total++;
        if (fifo_count !== '0 || out_valid !== 1'b0) $display("FAIL rst_nowrite: got count %0d valid %b, required 0/0", fifo_count, out_valid); else passed++;
    endtask

    initial begin
        rst = 1'b1; rx_done_flag = 1'b0; rx_id_std = '0; rx_id_ext = '0; rx_ide = 1'b0;
        rx_remote_req = 1'b0; rx_dlc = '0;
        for (int i = 0; i < 8; i++) rx_data[i] = 8'h0;
        filter_en = 1'b0; acc_code = '0; acc_mask = '0;
        out_ready = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
        test_reset();
        test_basic();
        test_filter_std();
        test_filter_ext();
        test_overrun();
        test_full_pop();
        test_back_to_back();
        test_flush_rst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/can_rx_msg_ctrl.md
CAN_RX_MSG_CTRL -- requirements
Module: can_rx_msg_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, message FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have inputs from receiver: rx_done_flag 1, rx_id_std 11, rx_id_ext 18, rx_ide 1, rx_remote_req 1, rx_dlc 4, rx_data [0:7] x 8 (received frame fields).
REQ-004 SHALL have config inputs: filter_en 1 (acceptance filter enable); acc_code 29; acc_mask 29 (1 = bit must match).
REQ-005 SHALL have host inputs: out_ready 1 (pop head); flush 1 (discard all entries); clr_overrun 1 (clear sticky flag).
REQ-006 SHALL have outputs: out_valid 1; out_id_std 11; out_id_ext 18; out_ide 1; out_rtr 1; out_dlc 4; out_data [0:7] x 8 (head entry); fifo_count $clog2(DEPTH)+1; overrun 1 (sticky); busy 1 (FSM not IDLE).

Function
REQ-007 SHALL detect a new frame on the rising edge of rx_done_flag (registered previous value); a level held across multiple clk cycles SHALL count as one frame.
REQ-008 FSM SHALL have states IDLE, FILTER, STORE; IDLE->FILTER on detected edge, snapshotting all rx_* fields that cycle; FILTER->STORE unconditionally; STORE->IDLE unconditionally.
REQ-009 In FILTER, accept SHALL be registered as: filter_en=0 -> 1; else ((rx_id_std ^ acc_code[28:18]) & acc_mask[28:18])==0 AND (ide=0 OR ((rx_id_ext ^ acc_code[17:0]) & acc_mask[17:0])==0); for ide=0, acc_mask[17:0] is ignored.
REQ-010 In STORE, an accepted snapshot SHALL be written if fifo_count<DEPTH or a pop occurs the same cycle; otherwise it SHALL be dropped and overrun set.
REQ-011 Rejected frames SHALL be dropped silently, no flag change.
REQ-012 A detected edge while FSM not IDLE SHALL drop that frame and set overrun.
REQ-013 Latency: edge seen in cycle N -> out_valid high in cycle N+3 when FIFO was empty.
REQ-014 out_valid SHALL equal (fifo_count!=0); out_* SHALL present the oldest entry, stable while out_valid & !out_ready.
REQ-015 Pop SHALL occur on out_valid & out_ready; out_ready with out_valid=0 SHALL have no effect.
REQ-016 Simultaneous write and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 DLC>8 SHALL be stored unmodified; all 8 data bytes SHALL be stored regardless of DLC or RTR.
REQ-018 flush SHALL zero pointers and fifo_count next cycle, return FSM to IDLE discarding any snapshot, and take priority over write and pop; overrun unaffected.
REQ-019 clr_overrun SHALL clear overrun next cycle; a same-cycle set event SHALL win.

Reset
REQ-020 On rst: FSM IDLE, pointers and fifo_count 0, out_valid 0, overrun 0, busy 0, edge register 0, snapshot cleared; out_* data fields 0.
REQ-021 rst asserted mid-frame-capture SHALL discard the in-flight snapshot; no partial write.
REQ-022 Storage array contents need not reset; out_* SHALL read 0 while empty.

Structure
REQ-023 Shared package can_defs SHALL hold rx_msg_t struct (id_std, id_ext, ide, rtr, dlc, data[8]) and the FSM state enum for this block.
REQ-024 Storage SHALL be a sub-module can_msg_fifo (DEPTH x rx_msg_t, push/pop/flush, count); filtering and FSM stay in the top.

Verification
REQ-025 filter_en=0, one std frame id 0x123, dlc 2, data 0xAA,0x55, rx_done_flag held 5 cycles -> exactly one entry, out_valid at N+3, fields match, fifo_count=1.
REQ-026 filter_en=1, acc_code[28:18]=0x123, mask[28:18]=0x7FF; frames 0x123 and 0x124 -> only 0x123 stored.
REQ-027 Ext frame ide=1, id_ext 0x2ABCD, mask[17:0]=0x3FFFF, code[17:0]=0x2ABCD -> stored; id_ext 0x2ABCC -> dropped, overrun stays 0.
REQ-028 DEPTH=4, out_ready=0, push 5 accepted frames -> fifo_count=4, overrun=1, head = first frame; clr_overrun -> overrun=0.
REQ-029 FIFO full, STORE coincides with pop -> frame stored, fifo_count stays 4, overrun stays 0, order preserved.
REQ-030 flush and rst asserted during FILTER -> fifo_count=0, out_valid=0, FSM IDLE, no write next cycle.
